// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, scheduler FSM encoding, grant owner.
package aes_pkg;

  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STATE_SUB  = 3'd1,
    ST_STATE_DONE = 3'd2,
    ST_KEY_SUB    = 3'd3,
    ST_KEY_DONE   = 3'd4
  } fsm_e;

  typedef enum logic {
    GRANT_STATE = 1'b0,
    GRANT_KEY   = 1'b1
  } grant_e;

  // Flat FIPS-197 S-box: entry {row, col} = SBOX[{b[7:4], b[3:0]}].
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sbox_word.sv
// The single shared substitution lane: four parallel byte lookups.
module sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
  end

endmodule

// File: rtl/sub_bytes_scheduler.sv
// Time-shares one 32-bit S-box lane between the round datapath (4-word
// SubBytes) and the key expansion (single-word SubWord), round-robin.
module sub_bytes_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               state_req,
  input  logic [STATE_W-1:0] state_in,
  output logic               state_done,
  output logic [STATE_W-1:0] state_out,
  input  logic               key_req,
  input  logic [WORD_W-1:0]  key_word_in,
  output logic               key_done,
  output logic [WORD_W-1:0]  key_word_out,
  output logic               busy
);

  localparam logic [1:0] LAST_WORD = 2'(NUM_WORDS - 1);

  fsm_e               fsm_q, fsm_d;
  grant_e             last_q, last_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] in_q, in_d;
  logic [STATE_W-1:0] sout_q, sout_d;
  logic [WORD_W-1:0]  kout_q, kout_d;
  logic               sdone_q, sdone_d;
  logic               kdone_q, kdone_d;
  logic               grant_state_s;
  logic [WORD_W-1:0]  lane_in_s;
  logic [WORD_W-1:0]  lane_out_s;

  // Lane operand: the current state word, or word 0 for a key pass.
  always_comb begin
    if (fsm_q == ST_KEY_SUB) begin
      lane_in_s = in_q[WORD_W-1:0];
    end else begin
      lane_in_s = in_q[{cnt_q, 5'd0} +: WORD_W];
    end
  end

  sbox_word u_lane (
    .word_i (lane_in_s),
    .word_o (lane_out_s)
  );

  // Arbitration: state wins unless key also asks and state was served last.
  always_comb begin
    grant_state_s = state_req && (!key_req || (last_q == GRANT_KEY));
  end

  // Next-state logic; done pulses are delayed one cycle behind the DONE states.
  always_comb begin
    fsm_d   = fsm_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    sout_d  = sout_q;
    kout_d  = kout_q;
    sdone_d = (fsm_q == ST_STATE_DONE);
    kdone_d = (fsm_q == ST_KEY_DONE);
    case (fsm_q)
      ST_IDLE: begin
        if (grant_state_s) begin
          in_d   = state_in;
          cnt_d  = 2'd0;
          last_d = GRANT_STATE;
          fsm_d  = ST_STATE_SUB;
        end else if (key_req) begin
          in_d[WORD_W-1:0] = key_word_in;
          last_d = GRANT_KEY;
          fsm_d  = ST_KEY_SUB;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_STATE_SUB: begin
        sout_d[{cnt_q, 5'd0} +: WORD_W] = lane_out_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_WORD) begin
          fsm_d = ST_STATE_DONE;
        end else begin
          fsm_d = ST_STATE_SUB;
        end
      end
      ST_STATE_DONE: fsm_d = ST_IDLE;
      ST_KEY_SUB: begin
        kout_d = lane_out_s;
        fsm_d  = ST_KEY_DONE;
      end
      ST_KEY_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any transaction without a done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= ST_IDLE;
      last_q  <= GRANT_KEY;
      cnt_q   <= 2'd0;
      in_q    <= '0;
      sout_q  <= '0;
      kout_q  <= '0;
      sdone_q <= 1'b0;
      kdone_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      sout_q  <= sout_d;
      kout_q  <= kout_d;
      sdone_q <= sdone_d;
      kdone_q <= kdone_d;
    end
  end

  assign state_done   = sdone_q;
  assign key_done     = kdone_q;
  assign state_out    = sout_q;
  assign key_word_out = kout_q;
  assign busy         = (fsm_q != ST_IDLE);

endmodule

// File: tb/tb_sub_bytes_scheduler.sv
// Directed bench for sub_bytes_scheduler with hand-computed S-box results.
module tb_sub_bytes_scheduler;

  logic         clk;
  logic         n_rst;
  logic         state_req;
  logic [127:0] state_in;
  logic         state_done;
  logic [127:0] state_out;
  logic         key_req;
  logic [31:0]  key_word_in;
  logic         key_done;
  logic [31:0]  key_word_out;
  logic         busy;

  int total;
  int bad;

  localparam logic [127:0] S_A   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] S_A_X = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] S_B   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] S_B_X = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  K_A   = 32'hcf4f3c09;
  localparam logic [31:0]  K_A_X = 32'h8a84eb01;
  localparam logic [31:0]  K_B   = 32'h00ff5310;
  localparam logic [31:0]  K_B_X = 32'h6316edca;

  sub_bytes_scheduler dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .state_req    (state_req),
    .state_in     (state_in),
    .state_done   (state_done),
    .state_out    (state_out),
    .key_req      (key_req),
    .key_word_in  (key_word_in),
    .key_done     (key_done),
    .key_word_out (key_word_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one request already driven, then time its done pulse and busy span.
  task automatic run_txn(input bit is_key, input int exp_lat, input bit scramble, input string tag);
    int lat;
    int busy_n;
    bit pulse;
    lat = -1;
    step();
    state_req = 1'b0;
    key_req   = 1'b0;
    if (scramble) begin
      state_in    = ~state_in;
      key_word_in = ~key_word_in;
    end
    busy_n = busy ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      pulse = is_key ? key_done : state_done;
      if (pulse) begin
        lat = c;
        break;
      end
      busy_n += busy ? 1 : 0;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'(exp_lat));
    step();
    pulse = is_key ? key_done : state_done;
    check({tag, "_pulse_width"}, 128'(pulse), 128'd0);
  endtask

  initial begin
    int sd1;
    int sd2;
    int kd;
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    state_req = 1'b0;
    key_req   = 1'b0;
    state_in  = '0;
    key_word_in = '0;
    step();
    step();
    check("rst_state_done", 128'(state_done), 128'd0);
    check("rst_key_done", 128'(key_done), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_state_out", state_out, 128'd0);
    check("rst_key_word_out", 128'(key_word_out), 128'd0);
    n_rst = 1'b1;
    step();

    // Basic state SubBytes.
    state_req = 1'b1;
    state_in  = S_A;
    run_txn(1'b0, 5, 1'b0, "state1");
    check("state1_value", state_out, S_A_X);
    check("state1_busy_after", 128'(busy), 128'd0);

    // Basic key SubWord; state_out untouched.
    key_req     = 1'b1;
    key_word_in = K_A;
    run_txn(1'b1, 2, 1'b0, "key1");
    check("key1_value", 128'(key_word_out), 128'(K_A_X));
    check("key1_state_kept", state_out, S_A_X);

    // Simultaneous requests from reset, both held: STATE, KEY, STATE.
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    state_req = 1'b1;
    key_req   = 1'b1;
    state_in  = S_B;
    key_word_in = K_A;
    sd1 = -1;
    sd2 = -1;
    kd  = -1;
    for (int c = 0; c <= 14; c++) begin
      step();
      if (state_done) begin
        if (sd1 < 0) sd1 = c;
        else if (sd2 < 0) sd2 = c;
      end
      if (key_done && kd < 0) kd = c;
    end
    state_req = 1'b0;
    key_req   = 1'b0;
    check("arb_first_state_done", 128'(sd1), 128'd5);
    check("arb_key_done", 128'(kd), 128'd8);
    check("arb_second_state_done", 128'(sd2), 128'd14);
    check("arb_state_value", state_out, S_B_X);
    check("arb_key_value", 128'(key_word_out), 128'(K_A_X));
    step();
    step();
    check("arb_idle", 128'(busy), 128'd0);

    // Key input changed after acceptance is ignored.
    key_req     = 1'b1;
    key_word_in = K_B;
    run_txn(1'b1, 2, 1'b1, "key2");
    check("key2_value", 128'(key_word_out), 128'(K_B_X));
    check("key2_state_kept", state_out, S_B_X);

    // State input changed after acceptance is ignored.
    state_req = 1'b1;
    state_in  = S_A;
    run_txn(1'b0, 5, 1'b1, "state2");
    check("state2_value", state_out, S_A_X);
    check("state2_key_kept", 128'(key_word_out), 128'(K_B_X));

    // Reset while word_cnt==2 abandons the transaction.
    state_req = 1'b1;
    state_in  = S_B;
    step();
    state_req = 1'b0;
    step();
    step();
    n_rst = 1'b0;
    #1;
    check("midrst_state_out", state_out, 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_key_word_out", 128'(key_word_out), 128'd0);
    sd1 = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (state_done) sd1++;
    end
    check("midrst_no_done", 128'(sd1), 128'd0);
    n_rst = 1'b1;
    step();
    state_req = 1'b1;
    state_in  = S_B;
    run_txn(1'b0, 5, 1'b0, "postrst");
    check("postrst_value", state_out, S_B_X);

    // state_req held through done: second transaction after one IDLE cycle.
    state_req = 1'b1;
    state_in  = S_A;
    sd1 = -1;
    sd2 = -1;
    kd  = 0;
    for (int c = 0; c <= 11; c++) begin
      step();
      if (state_done) begin
        if (sd1 < 0) begin
          sd1 = c;
          check("held_first_value", state_out, S_A_X);
        end else if (sd2 < 0) begin
          sd2 = c;
        end
      end
      if (c == 6) kd = busy ? 1 : 0;
    end
    state_req = 1'b0;
    check("held_first_done", 128'(sd1), 128'd5);
    check("held_restart_busy", 128'(kd), 128'd1);
    check("held_second_done", 128'(sd2), 128'd11);
    check("held_second_value", state_out, S_A_X);
    step();
    step();
    check("held_idle", 128'(busy), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
